// File: rtl/riscv_pkg.sv
// Shared RV32I memory-access encodings: funct3 width codes, LSU fault codes and
// the load/store unit state encoding.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte strobes and replicated data, load
// extraction with sign/zero extension, and misalignment/illegal-width detection.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata,
    output logic [31:0] ext_rdata,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        shifted    = mem_rdata >> {offset, 3'b000};
        wstrb      = 4'b0000;
        lane_wdata = wdata;
        ext_rdata  = 32'd0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_LB: begin
                wstrb      = 4'b0001 << offset;
                lane_wdata = {4{wdata[7:0]}};
                ext_rdata  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_LH: begin
                wstrb      = 4'b0011 << offset;
                lane_wdata = {2{wdata[15:0]}};
                ext_rdata  = {{16{shifted[15]}}, shifted[15:0]};
                misaligned = offset[0];
            end
            F3_LW: begin
                wstrb      = 4'b1111;
                ext_rdata  = shifted;
                misaligned = (offset != 2'b00);
            end
            // Unsigned widths exist only for loads.
            F3_LBU: begin
                illegal    = is_store;
                ext_rdata  = {24'd0, shifted[7:0]};
            end
            F3_LHU: begin
                illegal    = is_store;
                ext_rdata  = {16'd0, shifted[15:0]};
                misaligned = offset[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store from the ALU, runs a req/ack access to data
// memory with a bounded wait, and returns extended load data plus a fault code.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             is_load,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       fault,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  fault_q, fault_d;

    logic        in_idle;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misaligned, al_illegal;

    // The aligner sees the live request while idle and the latched access otherwise.
    assign in_idle = (state_q == LSU_IDLE);

    lsu_align u_align (
        .funct3     (in_idle ? funct3 : funct3_q),
        .is_store   (in_idle ? is_store : store_q),
        .offset     (in_idle ? addr[1:0] : off_q),
        .wdata      (wdata),
        .mem_rdata  (mem_rdata),
        .wstrb      (al_wstrb),
        .lane_wdata (al_wdata),
        .ext_rdata  (al_rdata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        store_d     = store_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid && (is_load ^ is_store)) begin
                    rdata_d = 32'd0;
                    fault_d = FAULT_NONE;
                    cnt_d   = 8'd0;
                    if (al_illegal) begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = LSU_DONE;
                    end else if (al_misaligned) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = LSU_DONE;
                    end else begin
                        off_d       = addr[1:0];
                        funct3_d    = funct3;
                        store_d     = is_store;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wdata_d = is_store ? al_wdata : 32'd0;
                        mem_wstrb_d = is_store ? al_wstrb : 4'b0000;
                        state_d     = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is checked first so it wins over a coincident timeout.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    fault_d   = FAULT_NONE;
                    rdata_d   = store_q ? 32'd0 : al_rdata;
                    state_d   = LSU_DONE;
                end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                    mem_req_d = 1'b0;
                    fault_d   = FAULT_TIMEOUT;
                    rdata_d   = 32'd0;
                    state_d   = LSU_DONE;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LSU_IDLE;
            cnt_q       <= 8'd0;
            off_q       <= 2'd0;
            funct3_q    <= 3'd0;
            store_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'b0000;
            rdata_q     <= 32'd0;
            fault_q     <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            store_q     <= store_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign done      = (state_q == LSU_DONE);
    assign stall     = req_valid && !done;
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// compared cycle by cycle against a behavioural model of the memory stage.
module tb_load_store_unit;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .is_load   (is_load),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        int          w;      // cycles mem_req is high; done follows
        logic [1:0]  fault;
        logic [31:0] rdata;
        logic [31:0] strb;
        logic [31:0] wdata;
        logic [31:0] maddr;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // delay = WAIT cycles before ack (0 = ack in first WAIT cycle), negative = never.
    function automatic exp_t model(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] mrd, input int delay);
        exp_t e;
        int size, off;
        bit legal;
        logic [31:0] v, mask;
        off   = int'(a % 32'd4);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        e.maddr = a - (a % 32'd4);
        e.strb  = st ? (((32'd1 << size) - 32'd1) << off) : 32'd0;
        e.wdata = (size == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                  (size == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v    = (mrd >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
        e.rdata = 32'd0;
        if (!legal) begin
            e.w = 0; e.fault = 2'b11;
        end else if (off % size != 0) begin
            e.w = 0; e.fault = 2'b01;
        end else if (delay >= 0 && delay < MAX_WAIT) begin
            e.w = delay + 1; e.fault = 2'b00; e.rdata = ld ? v : 32'd0;
        end else begin
            e.w = MAX_WAIT; e.fault = 2'b10;
        end
        return e;
    endfunction

    // Runs one access starting and ending on a falling edge with the DUT idle.
    task automatic do_access(input bit ld, input bit st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] mrd, input int delay,
                             input bit late_ack, input string tag);
        exp_t e;
        e = model(ld, st, f3, a, wd, mrd, delay);
        @(negedge clk);
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        addr = a; wdata = wd; mem_rdata = mrd; mem_ack = 1'b0;
        for (int j = 1; j <= e.w + 1; j++) begin
            @(negedge clk);
            check({tag, " mem_req"}, 32'(mem_req), 32'(j <= e.w));
            check({tag, " done"}, 32'(done), 32'(j == e.w + 1));
            check({tag, " stall"}, 32'(stall), 32'(j != e.w + 1));
            if (j == 1 && e.w > 0) begin
                check({tag, " mem_we"}, 32'(mem_we), 32'(st));
                check({tag, " mem_addr"}, mem_addr, e.maddr);
                check({tag, " mem_wstrb"}, 32'(mem_wstrb), e.strb);
                if (st) check({tag, " mem_wdata"}, mem_wdata, e.wdata);
            end
            if (j == e.w + 1) begin
                check({tag, " rdata"}, rdata, e.rdata);
                check({tag, " fault"}, 32'(fault), 32'(e.fault));
            end
            mem_ack = (j - 1 == delay) && (j <= e.w);
        end
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " rdata held"}, rdata, e.rdata);
        mem_ack = late_ack;
        if (late_ack) begin
            @(negedge clk);
            mem_ack = 1'b0;
            check({tag, " late ack req"}, 32'(mem_req), 32'd0);
            check({tag, " late ack done"}, 32'(done), 32'd0);
        end
    endtask

    exp_t pin;

    initial begin
        reset = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset mem_wstrb", 32'(mem_wstrb), 32'd0);

        pin = model(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 0);
        check("model LB", pin.rdata, 32'hFFFF_FF80);
        pin = model(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 0);
        check("model LBU", pin.rdata, 32'h0000_0080);
        pin = model(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF_0000, 0);
        check("model LHU", pin.rdata, 32'h0000_80FF);
        pin = model(1'b0, 1'b1, 3'b000, 32'h21, 32'h1234_56AB, 32'd0, 0);
        check("model SB wdata", pin.wdata, 32'hABAB_ABAB);
        check("model SB strb", pin.strb, 32'h2);
        pin = model(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234_56AB, 32'd0, 0);
        check("model SH wdata", pin.wdata, 32'h56AB_56AB);
        check("model SH strb", pin.strb, 32'hC);

        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 1, 1'b0, "LW");
        check("LW rdata literal", rdata, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h0BAD_F00D, 0, 1'b0, "LW zero-wait");
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 0, 1'b0, "LB");
        check("LB rdata literal", rdata, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 0, 1'b0, "LBU");
        check("LBU rdata literal", rdata, 32'h0000_0080);
        do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF_0000, 2, 1'b0, "LHU");
        check("LHU rdata literal", rdata, 32'h0000_80FF);
        do_access(1'b0, 1'b1, 3'b000, 32'h21, 32'h1234_56AB, 32'd0, 0, 1'b0, "SB");
        do_access(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234_56AB, 32'd0, 1, 1'b0, "SH");
        do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0, 1'b0, "LW misaligned");
        check("LW misaligned literal", 32'(fault), 32'd1);
        do_access(1'b0, 1'b1, 3'b001, 32'h101, 32'h5555, 32'd0, 0, 1'b0, "SH misaligned");
        do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0, 1'b0, "load f3=011");
        check("illegal literal", 32'(fault), 32'd3);
        do_access(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 32'd0, 0, 1'b0, "store f3=100");
        do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h1111_2222, -1, 1'b1, "timeout");
        check("timeout literal", 32'(fault), 32'd2);
        do_access(1'b1, 1'b0, 3'b010, 32'h304, 32'd0, 32'h3333_4444, MAX_WAIT - 1, 1'b0, "ack at limit");

        // Neither or both directions: never accepted.
        @(negedge clk);
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h40;
        repeat (3) begin
            @(negedge clk);
            check("both dirs mem_req", 32'(mem_req), 32'd0);
            check("both dirs done", 32'(done), 32'd0);
            check("both dirs stall", 32'(stall), 32'd1);
        end
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;

        // Reset in WAIT abandons the access.
        @(negedge clk);
        req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        check("pre-reset mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset mem_req", 32'(mem_req), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        reset = 1'b0; req_valid = 1'b0; is_load = 1'b0;
        @(negedge clk);
        check("post reset done", 32'(done), 32'd0);
        check("post reset mem_req", 32'(mem_req), 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'hCAFE_0001, 0, 1'b0, "LW after reset");

        for (int i = 0; i < 200; i++) begin
            bit ld;
            ld = 1'($urandom % 2);
            do_access(ld, !ld, 3'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, MAX_WAIT + 1)) - 1, 1'($urandom % 4 == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
